// File: rtl/spi_ctrl_pkg.sv
// Shared types and default constants for the SPI transfer scheduler.
// The FSM state encoding and parameter defaults live here for the top and its arbiter.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CFG_W       = 32;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin one-hot selector: the lowest requester at or above i_ptr wins,
// otherwise the search wraps around to the lowest requester overall.
module spi_rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_hi
      assign w_hi[gi] = i_req[gi] && (PTR_W'(gi) >= i_ptr);
    end
  endgenerate

  // Two-level priority: masked upper region first, then the full vector (wrap).
  assign w_pick  = (|w_hi) ? w_hi : i_req;
  assign o_grant = w_pick & (~w_pick + N_REQ'(1));

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI core among N_REQ requesters: round-robin grant, config/start
// handshake to the core, interrupt wait with timeout, and a one-cycle done pulse.
module spi_xfer_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CFG_W       = DEF_CFG_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ*CFG_W-1:0]  i_req_cfg,
  output logic [N_REQ-1:0]        o_grant,
  output logic [N_REQ-1:0]        o_done,
  output logic                    o_timeout,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic [DATA_W-1:0]       o_spi_data,
  output logic [CFG_W-1:0]        o_spi_config,
  output logic                    o_spi_trans_en,
  input  logic                    i_spi_interrupt,
  input  logic [DATA_W-1:0]       i_spi_rdata,
  output logic                    o_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_done;
  logic                r_timeout;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [DATA_W-1:0]   r_spi_data;
  logic [CFG_W-1:0]    r_spi_config;
  logic                r_trans_en;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic [N_REQ-1:0]    w_win;
  logic [PTR_W-1:0]    w_win_idx;
  logic [PTR_W-1:0]    w_next_ptr;
  logic [DATA_W-1:0]   w_win_data;
  logic [CFG_W-1:0]    w_win_cfg;
  logic [CNT_W-1:0]    w_cnt_inc;

  spi_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_win)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    w_win_cfg  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win[k]) begin
        w_win_idx  = w_win_idx | PTR_W'(k);
        w_win_data = w_win_data | i_req_data[k*DATA_W +: DATA_W];
        w_win_cfg  = w_win_cfg | i_req_cfg[k*CFG_W +: CFG_W];
      end
    end
  end

  assign w_next_ptr = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);

  // Counts START plus WAIT clocks; it reaches TIMEOUT_CYC on the edge that would leave WAIT.
  assign w_cnt_inc = (r_cnt == CNT_W'(TIMEOUT_CYC)) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_timeout    <= 1'b0;
      r_rsp_data   <= '0;
      r_spi_data   <= '0;
      r_spi_config <= '0;
      r_trans_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_done    <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_grant      <= w_win;
            r_ptr        <= w_next_ptr;
            r_spi_data   <= w_win_data;
            r_spi_config <= w_win_cfg;
            r_busy       <= 1'b1;
            r_state      <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          r_trans_en <= 1'b1;
          r_cnt      <= '0;
          r_state    <= ST_START;
        end
        ST_START: begin
          r_trans_en <= 1'b0;
          r_cnt      <= w_cnt_inc;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_inc;
          // Interrupt is checked first so a coincident timeout still counts as success.
          if (i_spi_interrupt) begin
            r_rsp_data <= i_spi_rdata;
            r_done     <= r_grant;
            r_state    <= ST_DONE;
          end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
            r_rsp_data <= '0;
            r_done     <= r_grant;
            r_timeout  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_rsp_data   <= '0;
          r_spi_data   <= '0;
          r_spi_config <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant        = r_grant;
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;
  assign o_rsp_data     = r_rsp_data;
  assign o_spi_data     = r_spi_data;
  assign o_spi_config   = r_spi_config;
  assign o_spi_trans_en = r_trans_en;
  assign o_busy         = r_busy;

endmodule

// File: doc/spi_xfer_scheduler.md
SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one SPI core (2..8).
REQ-002 Parameter DATA_W, default 8, SHALL set the transfer data width.
REQ-003 Parameter CFG_W, default 32, SHALL set the SPI config word width (C1, C2, status, baud bytes).
REQ-004 Parameter TIMEOUT_CYC, default 4096, SHALL set the interrupt-wait limit in clocks.
REQ-005 i_sys_clk  input  1  sole clock; all logic SHALL be rising-edge.
REQ-006 i_sys_rst  input  1  reset; asynchronous and active-high.
REQ-007 i_req  input  N_REQ  per-requester level request; held until its o_done pulse.
REQ-008 i_req_data  input  N_REQ*DATA_W  per-requester TX byte, slice k at [k*DATA_W +: DATA_W].
REQ-009 i_req_cfg  input  N_REQ*CFG_W  per-requester config word, same slicing.
REQ-010 o_grant  output  N_REQ  one-hot owner of the SPI core; zero when idle.
REQ-011 o_done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-012 o_timeout  output  1  one-cycle pulse, concurrent with o_done, when the transfer timed out.
REQ-013 o_rsp_data  output  DATA_W  RX byte, valid while o_done is high.
REQ-014 o_spi_data  output  DATA_W  to core i_data.
REQ-015 o_spi_config  output  CFG_W  to core i_data_config.
REQ-016 o_spi_trans_en  output  1  to core i_trans_en.
REQ-017 i_spi_interrupt  input  1  from core o_interrupt; transfer-complete indication.
REQ-018 i_spi_rdata  input  DATA_W  from core o_data.
REQ-019 o_busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, CONFIG, START, WAIT, DONE.
REQ-021 IDLE: if any i_req is high, the round-robin arbiter SHALL select the winner and latch its data and config next clock, moving to CONFIG; else remain.
REQ-022 Round-robin priority SHALL start at the index after the last granted requester; after reset, index 0 has highest priority.
REQ-023 CONFIG SHALL drive o_spi_config and o_spi_data from the latched values for exactly one clock with o_spi_trans_en low, then go to START.
REQ-024 START SHALL assert o_spi_trans_en for exactly one clock, then go to WAIT.
REQ-025 WAIT SHALL hold o_spi_config and o_spi_data stable and count clocks; on i_spi_interrupt high, it SHALL capture i_spi_rdata and go to DONE.
REQ-026 If the WAIT counter reaches TIMEOUT_CYC without an interrupt, the FSM SHALL go to DONE with o_timeout set and o_rsp_data = 0.
REQ-027 DONE SHALL pulse o_done[owner] (and o_timeout if flagged) for one clock, then return to IDLE; o_grant SHALL drop on the same edge.
REQ-028 An interrupt arriving in the same cycle the counter hits TIMEOUT_CYC SHALL count as success (no timeout).
REQ-029 i_spi_interrupt outside WAIT SHALL be ignored.
REQ-030 Deassertion of the owner's i_req mid-transfer SHALL NOT abort; the transfer completes and o_done still pulses.
REQ-031 Minimum request-to-done latency SHALL be 4 clocks plus core transfer time; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-032 Counter width SHALL be $clog2(TIMEOUT_CYC+1) bits, saturating without wrap.

Reset
REQ-033 On i_sys_rst high, the FSM SHALL enter IDLE and all outputs SHALL be 0 (o_grant, o_done, o_timeout, o_rsp_data, o_spi_*, o_busy), with the RR pointer at index 0.
REQ-034 Reset mid-transfer SHALL abandon the transfer with no o_done pulse.

Structure
REQ-035 State enum and default parameter constants SHALL reside in package spi_ctrl_pkg.
REQ-036 Round-robin selection SHALL be a sub-module spi_rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-037 Single requester 1, cfg 32'hD6108011, data 8'hA5, core loopback -> o_spi_trans_en one pulse, o_done[1] with o_rsp_data 8'hA5, o_timeout 0.
REQ-038 All four i_req high simultaneously after reset -> grants in order 0,1,2,3, each with one o_done.
REQ-039 Interrupt tied low, TIMEOUT_CYC=16 -> o_done and o_timeout pulse together 16 clocks after START, o_rsp_data 0.
REQ-040 i_sys_rst asserted during WAIT -> all outputs 0 immediately, no o_done; next request granted to index 0.
REQ-041 Interrupt and timeout coincide -> o_done high with o_timeout low, captured data returned.
REQ-042 Owner drops i_req during WAIT -> transfer completes, o_done pulses once, next grant goes to the following index.
